// File: rtl/permutation_controller.sv
// Line sequencer for the line-register/permutation datapath: for each line it
// reads the source memory, loads the line register, then writes the permuted line.
module permutation_controller #(
  parameter int LINE_COUNT = 25,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  outReady,
  output logic                  busy,
  output logic                  rdEn,
  output logic [ADDR_WIDTH-1:0] rdAddr,
  output logic                  lineRegLoad,
  output logic                  wrEn,
  output logic [ADDR_WIDTH-1:0] wrAddr,
  output logic [ADDR_WIDTH-1:0] lineIndex,
  output logic                  done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    LOAD  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LastLine = ADDR_WIDTH'(LINE_COUNT - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  // State and line counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter update; the terminal compare keeps the counter from wrapping
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      READ:  state_d = LOAD;
      LOAD:  state_d = WRITE;
      WRITE: begin
        if (!outReady) begin
          state_d = WRITE;
        end else if (cnt_q == LastLine) begin
          state_d = DONE;
        end else begin
          state_d = READ;
          cnt_d   = cnt_q + ADDR_WIDTH'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decode from the registers; wrEn is gated by outReady so a stall never writes
  assign busy        = (state_q != IDLE);
  assign rdEn        = (state_q == READ);
  assign lineRegLoad = (state_q == LOAD);
  assign wrEn        = (state_q == WRITE) && outReady;
  assign done        = (state_q == DONE);
  assign rdAddr      = cnt_q;
  assign wrAddr      = cnt_q;
  assign lineIndex   = cnt_q;

endmodule

// File: tb/tb_permutation_controller.sv
// Directed bench for permutation_controller with LINE_COUNT = 4, 1 and 32 instances.
module tb_permutation_controller;

  logic clk, rst;
  logic start4, ready4, start1, ready1, start32, ready32;

  logic       busy4, rd4, ld4, wr4, dn4;
  logic [4:0] ra4, wa4, li4;
  logic       busy1, rd1, ld1, wr1, dn1;
  logic [4:0] ra1, wa1, li1;
  logic       busy32, rd32, ld32, wr32, dn32;
  logic [4:0] ra32, wa32, li32;

  int checks   = 0;
  int failures = 0;

  permutation_controller #(.LINE_COUNT(4), .ADDR_WIDTH(5)) u4 (
    .clk(clk), .rst(rst), .start(start4), .outReady(ready4), .busy(busy4),
    .rdEn(rd4), .rdAddr(ra4), .lineRegLoad(ld4), .wrEn(wr4), .wrAddr(wa4),
    .lineIndex(li4), .done(dn4));

  permutation_controller #(.LINE_COUNT(1), .ADDR_WIDTH(5)) u1 (
    .clk(clk), .rst(rst), .start(start1), .outReady(ready1), .busy(busy1),
    .rdEn(rd1), .rdAddr(ra1), .lineRegLoad(ld1), .wrEn(wr1), .wrAddr(wa1),
    .lineIndex(li1), .done(dn1));

  permutation_controller #(.LINE_COUNT(32), .ADDR_WIDTH(5)) u32 (
    .clk(clk), .rst(rst), .start(start32), .outReady(ready32), .busy(busy32),
    .rdEn(rd32), .rdAddr(ra32), .lineRegLoad(ld32), .wrEn(wr32), .wrAddr(wa32),
    .lineIndex(li32), .done(dn32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {busy, rdEn, lineRegLoad, wrEn, done, rdAddr, wrAddr, lineIndex}
  logic [19:0] obs4, obs1;
  assign obs4 = {busy4, rd4, ld4, wr4, dn4, ra4, wa4, li4};
  assign obs1 = {busy1, rd1, ld1, wr1, dn1, ra1, wa1, li1};

  // Source memory (one-cycle read latency) and line register around u4
  logic [7:0] src_mem [4];
  logic [7:0] mem_dout, line_reg;
  logic [7:0] exp_perm [4];
  initial begin
    src_mem[0] = 8'h01; src_mem[1] = 8'h02; src_mem[2] = 8'h03; src_mem[3] = 8'h04;
    exp_perm[0] = 8'h80; exp_perm[1] = 8'h40; exp_perm[2] = 8'hC0; exp_perm[3] = 8'h20;
  end
  always @(posedge clk) begin
    if (rd4) mem_dout <= src_mem[ra4[1:0]];
    if (ld4) line_reg <= mem_dout;
  end

  function automatic logic [7:0] permute(input logic [7:0] v);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) r[b] = v[7-b];
    return r;
  endfunction

  // Expected u4 outputs j cycles after the sampling start edge (timing formula 3i+phase)
  function automatic logic [19:0] exp4(input int j, input int sl, input int sn, input bit hold);
    int t;
    logic [4:0] a;
    logic [4:0] f;
    t = j;
    if (sn > 0 && j >= 3*sl + 2) begin
      if (j < 3*sl + 2 + sn) begin
        a = 5'(sl);
        return {5'b10000, a, a, a};
      end
      t = j - sn;
    end
    if (hold && t >= 14) t = t - 14;
    if (t < 12) begin
      a = 5'(t / 3);
      f = (t % 3 == 0) ? 5'b11000 : (t % 3 == 1) ? 5'b10100 : 5'b10010;
    end else if (t == 12) begin
      a = 5'd3;
      f = 5'b10001;
    end else begin
      a = 5'd0;
      f = 5'b00000;
    end
    return {f, a, a, a};
  endfunction

  task automatic test_reset;
    rst = 1'b0; start4 = 1'b0; start1 = 1'b0; start32 = 1'b0;
    ready4 = 1'b1; ready1 = 1'b1; ready32 = 1'b1;
    #7 rst = 1'b1;
    #1;
    checks++;
    if ({obs4, obs1, busy32, rd32, ld32, wr32, dn32, ra32, wa32, li32} !== 60'd0) begin
      failures++;
      $display("FAIL reset_immediate obs4=%h obs1=%h busy32=%b want all zero", obs4, obs1, busy32);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (obs4 !== 20'd0 || obs1 !== 20'd0 || {busy32, rd32, ld32, wr32, dn32} !== 5'd0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d obs4=%h obs1=%h want 0", i, obs4, obs1);
      end
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs4 !== 20'd0) begin
      failures++;
      $display("FAIL idle_after_reset obs4=%h want 0", obs4);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_nominal;
    start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    for (int j = 0; j < 15; j++) begin
      ready4 = 1'b1;
      @(negedge clk);
      checks++;
      if (obs4 !== exp4(j, 0, 0, 1'b0)) begin
        failures++;
        $display("FAIL nominal j=%0d got=%h want=%h", j, obs4, exp4(j, 0, 0, 1'b0));
      end
      if (wr4) begin
        checks++;
        if (permute(line_reg) !== exp_perm[wa4[1:0]]) begin
          failures++;
          $display("FAIL nominal_data line=%0d got=%h want=%h", wa4, permute(line_reg), exp_perm[wa4[1:0]]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall;
    start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    for (int j = 0; j < 18; j++) begin
      ready4 = (j >= 8 && j < 11) ? 1'b0 : 1'b1;
      @(negedge clk);
      checks++;
      if (obs4 !== exp4(j, 2, 3, 1'b0)) begin
        failures++;
        $display("FAIL stall j=%0d got=%h want=%h", j, obs4, exp4(j, 2, 3, 1'b0));
      end
      if (wr4) begin
        checks++;
        if (permute(line_reg) !== exp_perm[wa4[1:0]]) begin
          failures++;
          $display("FAIL stall_data line=%0d got=%h want=%h", wa4, permute(line_reg), exp_perm[wa4[1:0]]);
        end
      end
      @(posedge clk); #1;
    end
    ready4 = 1'b1;
  endtask

  task automatic test_ignored_start;
    start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    for (int j = 0; j < 17; j++) begin
      start4 = (j == 4) ? 1'b1 : 1'b0;
      @(negedge clk);
      checks++;
      if (obs4 !== exp4(j, 0, 0, 1'b0)) begin
        failures++;
        $display("FAIL ignored_start j=%0d got=%h want=%h", j, obs4, exp4(j, 0, 0, 1'b0));
      end
      @(posedge clk); #1;
    end
    start4 = 1'b0;
  endtask

  task automatic test_back_to_back;
    bit seen;
    start4 = 1'b1;
    @(posedge clk); #1;
    for (int j = 0; j < 17; j++) begin
      if (j == 15) start4 = 1'b0;
      @(negedge clk);
      checks++;
      if (obs4 !== exp4(j, 0, 0, 1'b1)) begin
        failures++;
        $display("FAIL back_to_back j=%0d got=%h want=%h", j, obs4, exp4(j, 0, 0, 1'b1));
      end
      @(posedge clk); #1;
    end
    start4 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (dn4) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (!seen || busy4 !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back_second_done seen=%b busy=%b want 1/0", seen, busy4);
    end
  endtask

  task automatic test_reset_midrun;
    bit seen;
    start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
    end
    ready4 = 1'b1;
    #1;
    checks++;
    if (wr4 !== 1'b1 || wa4 !== 5'd2) begin
      failures++;
      $display("FAIL midrun_pre_write wrEn=%b wrAddr=%0d want 1/2", wr4, wa4);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (obs4 !== 20'd0) begin
      failures++;
      $display("FAIL midrun_reset got=%h want 0", obs4);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs4 !== 20'd0) begin
      failures++;
      $display("FAIL midrun_stays_idle got=%h want 0", obs4);
    end
    @(posedge clk); #1 start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    @(negedge clk);
    checks++;
    if (obs4 !== exp4(0, 0, 0, 1'b0)) begin
      failures++;
      $display("FAIL midrun_restart got=%h want=%h", obs4, exp4(0, 0, 0, 1'b0));
    end
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (dn4) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL midrun_restart_done seen=%b want 1", seen);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_edge_params;
    logic [19:0] want1 [5];
    int writes;
    int last_wa;
    int done_j;
    want1[0] = {5'b11000, 15'd0};
    want1[1] = {5'b10100, 15'd0};
    want1[2] = {5'b10010, 15'd0};
    want1[3] = {5'b10001, 15'd0};
    want1[4] = {5'b00000, 15'd0};
    start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      checks++;
      if (obs1 !== want1[j]) begin
        failures++;
        $display("FAIL lc1 j=%0d got=%h want=%h", j, obs1, want1[j]);
      end
      @(posedge clk); #1;
    end
    writes = 0; last_wa = -1; done_j = -1;
    start32 = 1'b1;
    @(posedge clk); #1 start32 = 1'b0;
    for (int j = 0; j < 98; j++) begin
      @(negedge clk);
      if (wr32) begin
        checks++;
        if (wa32 !== 5'(writes)) begin
          failures++;
          $display("FAIL lc32_wraddr n=%0d got=%0d want=%0d", writes, wa32, writes);
        end
        last_wa = int'(wa32);
        writes++;
      end
      if (dn32) done_j = j;
      @(posedge clk); #1;
    end
    checks++;
    if (writes !== 32 || last_wa !== 31 || done_j !== 96 || busy32 !== 1'b0) begin
      failures++;
      $display("FAIL lc32_run writes=%0d last=%0d done_j=%0d busy=%b want 32/31/96/0",
               writes, last_wa, done_j, busy32);
    end
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_stall;
    test_ignored_start;
    test_back_to_back;
    test_reset_midrun;
    test_edge_params;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
